pipe_hazard_ctrl: RTL and testbench

- Generates the per-stage stall and bubble controls consumed by every pipeline register in the 5-stage RISC-V core.
- Resolves four hazard classes:
  - data-memory wait;
  - multi-cycle accelerator operation;
  - taken branch/jump flush;
  - load-use dependency.
- Owns the accelerator start/done handshake FSM and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_acc_seq.sv | 75 +++++++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Imported by the accelerator sequencer and the hazard decode top.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF       = 5;
    localparam int ACC_TIMEOUT_DEF = 1024;
    localparam int CNT_W_DEF       = 32;

    typedef enum logic [2:0] {
        NONE,
        LOADUSE,
        FLUSH,
        ACCW,
        MEMW
    } cause_e;

    typedef enum logic {
        IDLE,
        BUSY
    } acc_state_e;

endpackage

// File: rtl/pipe_acc_seq.sv
// Accelerator start/done handshake with a BUSY watchdog.
// busy_hold tells the hazard decode to keep the pipeline frozen.
module pipe_acc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int ACC_TIMEOUT = ACC_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic acc_req,
    input  logic acc_done,
    input  logic mem_wait,
    output logic acc_start,
    output logic acc_busy,
    output logic acc_timeout,
    output logic busy_hold
);

    localparam int TW = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(ACC_TIMEOUT - 1);

    acc_state_e state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_start   = 1'b0;
        acc_timeout = 1'b0;
        busy_hold   = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc_req) begin
                    busy_hold = 1'b1;
                    // A launch is deferred while memory holds the EX stage
                    if (!mem_wait) begin
                        acc_start = 1'b1;
                        state_nxt = BUSY;
                        cnt_nxt   = '0;
                    end
                end
            end
            BUSY: begin
                if (acc_done) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    acc_timeout = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    busy_hold = 1'b1;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            acc_start   = 1'b0;
            acc_timeout = 1'b0;
            busy_hold   = 1'b0;
        end
    end

    assign acc_busy = (state == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/bubble generation for the 5-stage core.
// Priority: memory wait, accelerator, flush, load-use.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int ACC_TIMEOUT = ACC_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             ex_acc_req,
    input  logic             acc_done,
    input  logic             mem_wait,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             bubble_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             stall_mem,
    output logic             bubble_mem,
    output logic             stall_wb,
    output logic             bubble_wb,
    output logic             acc_start,
    output logic             acc_busy,
    output logic             acc_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    logic   busy_hold;
    logic   load_use;
    cause_e cause;

    pipe_acc_seq #(
        .ACC_TIMEOUT(ACC_TIMEOUT)
    ) u_acc_seq (
        .clk        (clk),
        .rst        (rst),
        .acc_req    (ex_acc_req),
        .acc_done   (acc_done),
        .mem_wait   (mem_wait),
        .acc_start  (acc_start),
        .acc_busy   (acc_busy),
        .acc_timeout(acc_timeout),
        .busy_hold  (busy_hold)
    );

    // x0 is hardwired, so a load targeting it never blocks ID
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        cause = NONE;
        if (rst)
            cause = NONE;
        else if (mem_wait)
            cause = MEMW;
        else if (busy_hold)
            cause = ACCW;
        else if (ex_br_taken && !ex_acc_req)
            cause = FLUSH;
        else if (load_use)
            cause = LOADUSE;
    end

    always_comb begin
        stall_pc   = 1'b0;
        stall_id   = 1'b0;
        bubble_id  = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        stall_mem  = 1'b0;
        bubble_mem = 1'b0;
        stall_wb   = 1'b0;
        bubble_wb  = 1'b0;
        unique case (cause)
            MEMW: begin
                stall_pc  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end
            ACCW: begin
                stall_pc   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
            end
            FLUSH: begin
                bubble_id = 1'b1;
                bubble_ex = 1'b1;
            end
            LOADUSE: begin
                stall_pc  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_pc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks of hazard priority, accelerator handshake,
// watchdog timeout, async reset and stall counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int ACC_TIMEOUT = 8;
    localparam int CNT_W = 4;

    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_LU   = 9'b110010000;
    localparam logic [8:0] C_FL   = 9'b001010000;
    localparam logic [8:0] C_ACC  = 9'b110100100;
    localparam logic [8:0] C_MEM  = 9'b110101001;

    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used;
    logic ex_mem_read, ex_br_taken, ex_acc_req;
    logic acc_done, mem_wait;
    logic stall_pc, stall_id, bubble_id, stall_ex, bubble_ex;
    logic stall_mem, bubble_mem, stall_wb, bubble_wb;
    logic acc_start, acc_busy, acc_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [8:0] ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl = {stall_pc, stall_id, bubble_id, stall_ex, bubble_ex,
                  stall_mem, bubble_mem, stall_wb, bubble_wb};

    pipe_hazard_ctrl #(
        .REG_W(REG_W),
        .ACC_TIMEOUT(ACC_TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_br_taken(ex_br_taken), .ex_acc_req(ex_acc_req),
        .acc_done(acc_done), .mem_wait(mem_wait),
        .stall_pc(stall_pc), .stall_id(stall_id), .bubble_id(bubble_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .stall_mem(stall_mem), .bubble_mem(bubble_mem),
        .stall_wb(stall_wb), .bubble_wb(bubble_wb),
        .acc_start(acc_start), .acc_busy(acc_busy),
        .acc_timeout(acc_timeout), .stall_cycles(stall_cycles)
    );

    task automatic clear_in();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0;
        ex_mem_read = 0; ex_br_taken = 0; ex_acc_req = 0;
        acc_done = 0; mem_wait = 0;
    endtask

    task automatic set_lu_hit();
        ex_mem_read = 1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_in();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_in();
        mem_wait = 1; ex_acc_req = 1; set_lu_hit();
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE);
        end
        checks++;
        if ({acc_start, acc_busy, acc_timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_acc got %b want 000",
                               {acc_start, acc_busy, acc_timeout});
        end
        checks++;
        if (stall_cycles !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); set_lu_hit(); #1;
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU);
        end
        @(negedge clk); clear_in(); #1;
        checks++;
        if (ctl !== C_NONE || stall_cycles !== 4'd1) begin
            errors++; $display("FAIL lu_after got %b/%0d want %b/1",
                               ctl, stall_cycles, C_NONE);
        end
        @(negedge clk);
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL lu_x0 got %b want %b", ctl, C_NONE);
        end
        @(negedge clk); clear_in();
        ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs1_used = 1;
        id_rs2 = 5'd7; id_rs2_used = 1; #1;
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU);
        end
        @(negedge clk); clear_in(); set_lu_hit(); id_rs1_used = 0; #1;
        checks++;
        if (ctl !== C_NONE || stall_cycles !== 4'd2) begin
            errors++; $display("FAIL lu_unused got %b/%0d want %b/2",
                               ctl, stall_cycles, C_NONE);
        end
        @(negedge clk); clear_in(); set_lu_hit(); ex_mem_read = 0; #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL lu_noload got %b want %b", ctl, C_NONE);
        end
    endtask

    task automatic test_flush_lu();
        do_reset();
        @(negedge clk); set_lu_hit(); ex_br_taken = 1; #1;
        checks++;
        if (ctl !== C_FL) begin
            errors++; $display("FAIL flush_lu got %b want %b", ctl, C_FL);
        end
        @(negedge clk); clear_in(); #1;
        checks++;
        if (stall_cycles !== 4'd0) begin
            errors++; $display("FAIL flush_cnt got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_accel();
        int starts = 0;
        do_reset();
        @(negedge clk); ex_acc_req = 1; #1;
        starts += int'(acc_start);
        checks++;
        if (acc_start !== 1'b1 || acc_busy !== 1'b0 || ctl !== C_ACC) begin
            errors++; $display("FAIL acc_c0 got s%b b%b %b want s1 b0 %b",
                               acc_start, acc_busy, ctl, C_ACC);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            starts += int'(acc_start);
            checks++;
            if (acc_busy !== 1'b1 || ctl !== C_ACC) begin
                errors++; $display("FAIL acc_c%0d got b%b %b want b1 %b",
                                   i, acc_busy, ctl, C_ACC);
            end
        end
        @(negedge clk); acc_done = 1; ex_br_taken = 1; #1;
        starts += int'(acc_start);
        checks++;
        if (acc_busy !== 1'b1 || ctl !== C_NONE) begin
            errors++; $display("FAIL acc_done got b%b %b want b1 %b",
                               acc_busy, ctl, C_NONE);
        end
        checks++;
        if (starts !== 1) begin
            errors++; $display("FAIL acc_starts got %0d want 1", starts);
        end
        @(negedge clk); clear_in(); #1;
        checks++;
        if (acc_busy !== 1'b0 || stall_cycles !== 4'd4) begin
            errors++; $display("FAIL acc_end got b%b cnt %0d want b0 cnt 4",
                               acc_busy, stall_cycles);
        end
        @(negedge clk); acc_done = 1; #1;
        @(negedge clk); acc_done = 0; #1;
        checks++;
        if (acc_busy !== 1'b0 || ctl !== C_NONE) begin
            errors++; $display("FAIL acc_idle_done got b%b %b want b0 %b",
                               acc_busy, ctl, C_NONE);
        end
    endtask

    task automatic test_timeout();
        int tmo = 0;
        do_reset();
        @(negedge clk); ex_acc_req = 1; #1;
        checks++;
        if (acc_start !== 1'b1) begin
            errors++; $display("FAIL tmo_start got %b want 1", acc_start);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            tmo += int'(acc_timeout);
            if (i == 8) begin
                checks++;
                if (acc_timeout !== 1'b1 || ctl !== C_NONE) begin
                    errors++; $display("FAIL tmo_pulse got t%b %b want t1 %b",
                                       acc_timeout, ctl, C_NONE);
                end
            end
        end
        checks++;
        if (tmo !== 1) begin
            errors++; $display("FAIL tmo_count got %0d want 1", tmo);
        end
        @(negedge clk); #1;
        checks++;
        if (acc_start !== 1'b1 || acc_busy !== 1'b0 || acc_timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_restart got s%b b%b t%b want s1 b0 t0",
                               acc_start, acc_busy, acc_timeout);
        end
        do_reset();
    endtask

    task automatic test_mem_wait_busy();
        int tmo = 0;
        do_reset();
        @(negedge clk); ex_acc_req = 1; mem_wait = 1; #1;
        checks++;
        if (acc_start !== 1'b0 || ctl !== C_MEM) begin
            errors++; $display("FAIL mw_nostart got s%b %b want s0 %b",
                               acc_start, ctl, C_MEM);
        end
        @(negedge clk); mem_wait = 0; #1;
        checks++;
        if (acc_start !== 1'b1 || acc_busy !== 1'b0) begin
            errors++; $display("FAIL mw_start got s%b b%b want s1 b0",
                               acc_start, acc_busy);
        end
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk); mem_wait = (i >= 4 && i <= 6); #1;
            tmo += int'(acc_timeout);
            if (i >= 4 && i <= 6) begin
                checks++;
                if (ctl !== C_MEM) begin
                    errors++; $display("FAIL mw_busy%0d got %b want %b",
                                       i, ctl, C_MEM);
                end
            end
        end
        checks++;
        if (tmo !== 1 || acc_timeout !== 1'b1) begin
            errors++; $display("FAIL mw_tmo got %0d/%b want 1/1",
                               tmo, acc_timeout);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1; #1;
        checks++;
        if (ctl !== C_NONE || {acc_start, acc_busy, acc_timeout} !== 3'b000) begin
            errors++; $display("FAIL mw_rst got %b %b want %b 000", ctl,
                               {acc_start, acc_busy, acc_timeout}, C_NONE);
        end
        @(negedge clk); @(negedge clk);
        rst = 0; clear_in();
        tmo = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            tmo += int'(acc_timeout) + int'(acc_busy);
        end
        checks++;
        if (tmo !== 0) begin
            errors++; $display("FAIL mw_abandon got %0d want 0", tmo);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk); set_lu_hit();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (i == 10) begin
                checks++;
                if (stall_cycles !== 4'd10) begin
                    errors++; $display("FAIL sat_mid got %0d want 10",
                                       stall_cycles);
                end
            end
        end
        @(negedge clk); clear_in(); #1;
        checks++;
        if (stall_cycles !== 4'd15) begin
            errors++; $display("FAIL sat_hold got %0d want 15", stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush_lu();
        test_accel();
        test_timeout();
        test_mem_wait_busy();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
